// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of nibble steps needed to cover a WIDTH-bit operand.
  function automatic int nibbles_of(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_if.sv
// Request/result bundle between a requester (master) and the adder (slave).
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit propagate/generate carry-lookahead adder.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [3:0] p, g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  // Each carry is a flat sum of products of g/p terms, no ripple chain.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice reused per nibble, LSB first.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nibble_serial_adder_if.slave  bus
);
  localparam int NIBBLES = nibbles_of(WIDTH);
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_t                          state;
  logic [IDX_W-1:0]                idx;
  logic                            carry_reg;
  logic [NIBBLES-1:0][NIBBLE_W-1:0] a_reg, b_reg, acc, acc_next;
  logic [WIDTH-1:0]                acc_flat_next;
  logic [NIBBLE_W-1:0]             slice_s;
  logic                            slice_cout;
  logic                            last;

  logic                            busy_q, done_q, cout_q, ovf_q;
  logic [WIDTH-1:0]                sum_q;

  cla4_slice u_slice (
    .a    (a_reg[idx]),
    .b    (b_reg[idx]),
    .cin  (carry_reg),
    .s    (slice_s),
    .cout (slice_cout)
  );

  // Merge the current slice result into the accumulator at nibble idx.
  always_comb begin
    acc_next      = acc;
    acc_next[idx] = slice_s;
  end

  assign acc_flat_next = acc_next;
  assign last          = (idx == IDX_W'(NIBBLES - 1));

  // Sequencer: operand capture, nibble stepping and result registration.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      acc       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            carry_reg <= bus.cin;
            idx       <= '0;
            acc       <= '0;
            busy_q    <= 1'b1;
            state     <= ADD;
          end else begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        ADD: begin
          acc       <= acc_next;
          carry_reg <= slice_cout;
          idx       <= idx + 1'b1;
          if (last) begin
            sum_q  <= acc_flat_next;
            cout_q <= slice_cout;
            ovf_q  <= (a_reg[NIBBLES-1][NIBBLE_W-1] == b_reg[NIBBLES-1][NIBBLE_W-1])
                   && (acc_flat_next[WIDTH-1] != a_reg[NIBBLES-1][NIBBLE_W-1]);
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;
  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  nibble_serial_adder_if #(.WIDTH(16)) bus ();

  nibble_serial_adder #(.WIDTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Step edges until done (bounded); report edges taken and busy samples seen.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      if (bus.busy === 1'b1) bc++;
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic run_add(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic cv, input logic [15:0] es, input logic ec, input logic eo);
    int n, bc;
    @(negedge clk);
    bus.a = av; bus.b = bv; bus.cin = cv; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n, bc);
    chk({tag, "_lat"},  n, 4);
    chk({tag, "_busy"}, bc, 4);
    chk({tag, "_sum"},  bus.sum, es);
    chk({tag, "_cout"}, bus.cout, ec);
    chk({tag, "_ovf"},  bus.overflow, eo);
  endtask

  initial begin
    int n, bc, seen;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sum", bus.sum, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cout", bus.cout, 0);
    chk("rst_ovf", bus.overflow, 0);
    @(negedge clk); reset = 1'b0;

    run_add("basic",  16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_add("rip_ci", 16'h0FFF, 16'hF000, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_add("ovf_p",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_add("ovf_n",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_add("neg",    16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0);

    // Start while busy is ignored.
    @(negedge clk);
    bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;                 // E0
    bus.start = 1'b0;
    @(posedge clk); #1;                 // second ADD cycle
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(n, bc);
    chk("hs_lat", n + 2, 4);
    chk("hs_sum", bus.sum, 16'h0002);
    // Start during DONE is accepted.
    bus.a = 16'h00FF; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("hs2_busy", bus.busy, 1);
    chk("hs2_done", bus.done, 0);
    wait_done(n, bc);
    chk("hs2_lat", n, 4);
    chk("hs2_sum", bus.sum, 16'h0100);

    // Reset mid-operation.
    run_add("pre_rst", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    @(negedge clk);
    bus.a = 16'h1234; bus.b = 16'h1111; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mr_sum", bus.sum, 0);
    chk("mr_cout", bus.cout, 0);
    chk("mr_ovf", bus.overflow, 0);
    chk("mr_busy", bus.busy, 0);
    chk("mr_done", bus.done, 0);
    @(negedge clk); reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("mr_nodone", seen, 0);
    run_add("post_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Hold: result stays put while inputs wiggle without start.
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.a = 16'h1111 * i; bus.b = ~bus.a; bus.cin = i[0];
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen++;
    end
    chk("hold_sum", bus.sum, 16'h0007);
    chk("hold_cout", bus.cout, 0);
    chk("hold_ovf", bus.overflow, 0);
    chk("hold_done", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
